// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : noc_pkg
//  Brief    : Shared flit width, credit counter width and link-TX FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int FLIT_W   = 8;
    localparam int CREDIT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_BLOCKED = 2'd2
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/link_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : link_tx_fifo
//  Brief    : Synchronous FIFO with show-ahead head, used as the link TX buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module link_tx_fifo
    import noc_pkg::*;
#(
    parameter int DATA_W = FLIT_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_wr;
    logic               w_rd;

    assign full_o    = (r_count == c_cnt_w'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign rd_data_o = r_mem[r_rptr];
    assign w_wr      = wr_en_i & ~full_o;
    assign w_rd      = rd_en_i & ~empty_o;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + c_cnt_w'(w_wr) - c_cnt_w'(w_rd);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr] <= wr_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/xy_link_tx.sv
`default_nettype none
// ============================================================================
//  Module   : xy_link_tx
//  Brief    : Credit-based output link transmitter for a mesh XY router port.
//             Define LINK_TX_STATS_EN to add tx_cnt_o / stall_cnt_o counters.
//  Revision : 1.0 - initial release
// ============================================================================
module xy_link_tx
    import noc_pkg::*;
#(
    parameter int DATA_W   = FLIT_W,
    parameter int TX_DEPTH = 4,
    parameter int CREDITS  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic              link_vld_o,
    output logic [DATA_W-1:0] link_data_o,
    input  logic              credit_i,
    output logic [1:0]        state_o,
    output logic              credit_err_o
`ifdef LINK_TX_STATS_EN
    ,
    output logic [15:0]       tx_cnt_o,
    output logic [15:0]       stall_cnt_o
`endif
);

    localparam int                  c_cnt_w      = $clog2(TX_DEPTH) + 1;
    localparam logic [CREDIT_W-1:0] c_credit_max = CREDIT_W'(CREDITS);

    logic [DATA_W-1:0]   w_head;
    logic                w_empty;
    logic [c_cnt_w-1:0]  w_count;
    logic                w_wr_acc;
    logic                w_pop;
    logic                w_cred_sat;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic [CREDIT_W-1:0] w_cred_next;
    logic [CREDIT_W-1:0] r_credits;
    logic                r_credit_err;
    logic                r_link_vld;
    logic [DATA_W-1:0]   r_link_data;
    tx_state_t           r_state;
    tx_state_t           w_state_next;

    link_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (TX_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en_i),
        .wr_data_i (data_i),
        .rd_en_i   (w_pop),
        .rd_data_o (w_head),
        .full_o    (full_o),
        .empty_o   (w_empty),
        .count_o   (w_count)
    );

    assign w_wr_acc   = wr_en_i & ~full_o;
    assign w_pop      = ~w_empty & (r_credits != '0);
    assign w_cnt_next = w_count + c_cnt_w'(w_wr_acc) - c_cnt_w'(w_pop);
    // A credit arriving at full count without a matching pop is a protocol error.
    assign w_cred_sat = credit_i & ~w_pop & (r_credits == c_credit_max);
    assign w_cred_next = w_cred_sat ? r_credits
                                    : r_credits - CREDIT_W'(w_pop) + CREDIT_W'(credit_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credits    <= c_credit_max;
            r_credit_err <= 1'b0;
            r_link_vld   <= 1'b0;
            r_link_data  <= '0;
            r_state      <= ST_IDLE;
        end else begin
            r_credits  <= w_cred_next;
            r_link_vld <= w_pop;
            r_state    <= w_state_next;
            if (w_cred_sat) r_credit_err <= 1'b1;
            if (w_pop)      r_link_data  <= w_head;
        end
    end

    // State tracks the post-edge buffer/credit situation; it never gates pop.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cnt_next != '0)
                    w_state_next = (w_cred_next != '0) ? ST_SEND : ST_BLOCKED;
            end
            ST_SEND: begin
                if (w_cnt_next == '0)       w_state_next = ST_IDLE;
                else if (w_cred_next == '0) w_state_next = ST_BLOCKED;
            end
            ST_BLOCKED: begin
                if (w_cnt_next == '0)       w_state_next = ST_IDLE;
                else if (w_cred_next != '0) w_state_next = ST_SEND;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign link_vld_o   = r_link_vld;
    assign link_data_o  = r_link_data;
    assign state_o      = r_state;
    assign credit_err_o = r_credit_err;

`ifdef LINK_TX_STATS_EN
    logic [15:0] r_tx_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop) r_tx_cnt <= r_tx_cnt + 16'd1;
            if ((r_state == ST_BLOCKED) && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign tx_cnt_o    = r_tx_cnt;
    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire
